// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS architectural-state dump engine.
package mips_dbg_pkg;

  localparam int unsigned WORD_BYTES = 4;

  // out_kind encodings
  localparam logic [1:0] KIND_PC  = 2'd0;
  localparam logic [1:0] KIND_REG = 2'd1;
  localparam logic [1:0] KIND_MEM = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StPc,
    StReq,
    StWait,
    StHold,
    StDone
  } dump_state_e;

  // Which section of the dump the current beat belongs to
  typedef enum logic [1:0] {
    PhPc,
    PhReg,
    PhMem
  } dump_phase_e;

endpackage

// File: rtl/mips_halt_detect.sv
// Halt detector: flags a core whose PC has not moved for STALL_CYCLES cycles.
// 'armed' stops a parked core from retriggering once its state has been dumped.
module mips_halt_detect
  import mips_dbg_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STALL_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              clr_armed,
  output logic              halt_trig
);

  localparam int unsigned CntW = $clog2(STALL_CYCLES + 1);

  logic [DATA_W-1:0] pc_prev_q;
  logic [CntW-1:0]   stall_cnt_q, stall_cnt_d;
  logic              armed_q, armed_d;
  logic              pc_moved;

  assign pc_moved = (pc_in != pc_prev_q);

  // Next-state: saturating stall counter; a PC move re-arms and wins over a clear
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    armed_d     = armed_q;
    if (pc_moved) begin
      stall_cnt_d = '0;
      armed_d     = 1'b1;
    end else begin
      if (stall_cnt_q != CntW'(STALL_CYCLES)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (clr_armed) begin
        armed_d = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_prev_q   <= '0;
      stall_cnt_q <= '0;
      armed_q     <= 1'b1;
    end else begin
      pc_prev_q   <= pc_in;
      stall_cnt_q <= stall_cnt_d;
      armed_q     <= armed_d;
    end
  end

  assign halt_trig = armed_q && (stall_cnt_q == CntW'(STALL_CYCLES));

endmodule

// File: rtl/mips_state_dump.sv
// Architectural-state dump engine: streams PC, register file and a data-memory
// window as tagged valid/ready beats after a start pulse or a detected halt.
module mips_state_dump
  import mips_dbg_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned NREGS        = 32,
  parameter int unsigned MEM_BASE     = 0,
  parameter int unsigned MEM_WORDS    = 9,
  parameter int unsigned READ_LAT     = 0,
  parameter int unsigned AUTO_TRIG    = 1,
  parameter int unsigned STALL_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pc_in,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [DATA_W-1:0] dm_raddr,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic [15:0]       out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  dump_state_e       state_q, state_d;
  dump_phase_e       phase_q, phase_d;
  logic [15:0]       idx_q, idx_d;
  logic [DATA_W-1:0] pc_snap_q, pc_snap_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_kind_q, out_kind_d;
  logic [15:0]       out_index_q, out_index_d;
  logic              halt_trig;
  logic              trig;
  logic              in_req;

  mips_halt_detect #(
    .DATA_W      (DATA_W),
    .STALL_CYCLES(STALL_CYCLES)
  ) u_halt (
    .clk      (clk),
    .rst      (rst),
    .pc_in    (pc_in),
    .clr_armed(state_q == StDone),
    .halt_trig(halt_trig)
  );

  assign trig = start || ((AUTO_TRIG != 0) && halt_trig);

  // Next-state logic: beat sequencing and output-register loads
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    pc_snap_d   = pc_snap_q;
    out_data_d  = out_data_q;
    out_kind_d  = out_kind_q;
    out_index_d = out_index_q;
    unique case (state_q)
      StIdle: begin
        if (trig) begin
          pc_snap_d = pc_in;
          state_d   = StPc;
        end
      end
      StPc: begin
        out_data_d  = pc_snap_q;
        out_kind_d  = KIND_PC;
        out_index_d = '0;
        phase_d     = PhPc;
        idx_d       = '0;
        state_d     = StHold;
      end
      StReq, StWait: begin
        // With zero latency the read data is already valid in REQ
        if (state_q == StWait || READ_LAT == 0) begin
          out_data_d  = (phase_q == PhReg) ? rf_rdata : dm_rdata;
          out_kind_d  = (phase_q == PhReg) ? KIND_REG : KIND_MEM;
          out_index_d = idx_q;
          state_d     = StHold;
        end else begin
          state_d = StWait;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StReq;
          case (phase_q)
            PhPc: begin
              idx_d = '0;
              if (NREGS != 0) phase_d = PhReg;
              else if (MEM_WORDS != 0) phase_d = PhMem;
              else state_d = StDone;
            end
            PhReg: begin
              if (idx_q == 16'(NREGS - 1)) begin
                idx_d = '0;
                if (MEM_WORDS != 0) phase_d = PhMem;
                else state_d = StDone;
              end else begin
                idx_d = idx_q + 16'd1;
              end
            end
            PhMem: begin
              if (idx_q == 16'(MEM_WORDS - 1)) state_d = StDone;
              else idx_d = idx_q + 16'd1;
            end
            default: state_d = StDone;
          endcase
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any dump in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      phase_q     <= PhPc;
      idx_q       <= '0;
      pc_snap_q   <= '0;
      out_data_q  <= '0;
      out_kind_q  <= '0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      pc_snap_q   <= pc_snap_d;
      out_data_q  <= out_data_d;
      out_kind_q  <= out_kind_d;
      out_index_q <= out_index_d;
    end
  end

  // Read addresses are held through REQ and WAIT, zero elsewhere
  always_comb begin
    in_req   = (state_q == StReq) || (state_q == StWait);
    rf_raddr = '0;
    dm_raddr = '0;
    if (in_req && phase_q == PhReg) begin
      rf_raddr = idx_q[4:0];
    end
    if (in_req && phase_q == PhMem) begin
      dm_raddr = DATA_W'(MEM_BASE) + DATA_W'(idx_q) * DATA_W'(WORD_BYTES);
    end
  end

  assign out_valid = (state_q == StHold);
  assign out_kind  = out_kind_q;
  assign out_index = out_index_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_mips_state_dump.sv
// Bench for mips_state_dump: three configurations, one beat monitor, beat
// lists predicted from the register/memory contents held in the bench.
`timescale 1ns/1ps
module tb_mips_state_dump;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a, start_b, start_c, ready;
  logic [31:0] pc;

  logic [4:0]  rf_raddr_a, rf_raddr_b, rf_raddr_c;
  logic [31:0] rf_rdata_a, rf_rdata_b, rf_rdata_c;
  logic [31:0] dm_raddr_a, dm_raddr_b, dm_raddr_c;
  logic [31:0] dm_rdata_a, dm_rdata_b, dm_rdata_c;
  logic [31:0] data_a, data_b, data_c;
  logic [1:0]  kind_a, kind_b, kind_c;
  logic [15:0] index_a, index_b, index_c;
  logic        valid_a, valid_b, valid_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;

  logic [31:0] rf  [32];
  logic [31:0] mem [64];

  // Core-side memories: a and c answer combinationally, b one cycle late
  assign rf_rdata_a = rf[rf_raddr_a];
  assign dm_rdata_a = mem[dm_raddr_a[7:2]];
  assign rf_rdata_c = rf[rf_raddr_c];
  assign dm_rdata_c = mem[dm_raddr_c[7:2]];
  always @(posedge clk) begin
    rf_rdata_b <= rf[rf_raddr_b];
    dm_rdata_b <= mem[dm_raddr_b[7:2]];
  end

  mips_state_dump dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pc_in(pc),
    .rf_raddr(rf_raddr_a), .rf_rdata(rf_rdata_a), .dm_raddr(dm_raddr_a), .dm_rdata(dm_rdata_a),
    .out_valid(valid_a), .out_ready(ready), .out_kind(kind_a), .out_index(index_a),
    .out_data(data_a), .busy(busy_a), .done(done_a)
  );

  mips_state_dump #(.NREGS(8), .MEM_WORDS(0), .READ_LAT(1), .AUTO_TRIG(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pc_in(pc),
    .rf_raddr(rf_raddr_b), .rf_rdata(rf_rdata_b), .dm_raddr(dm_raddr_b), .dm_rdata(dm_rdata_b),
    .out_valid(valid_b), .out_ready(ready), .out_kind(kind_b), .out_index(index_b),
    .out_data(data_b), .busy(busy_b), .done(done_b)
  );

  mips_state_dump #(.NREGS(4), .MEM_BASE(32'h20), .MEM_WORDS(2), .AUTO_TRIG(0)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .pc_in(pc),
    .rf_raddr(rf_raddr_c), .rf_rdata(rf_rdata_c), .dm_raddr(dm_raddr_c), .dm_rdata(dm_rdata_c),
    .out_valid(valid_c), .out_ready(ready), .out_kind(kind_c), .out_index(index_c),
    .out_data(data_c), .busy(busy_c), .done(done_c)
  );

  int total = 0;
  int passed = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Monitor of the selected DUT; beat = {kind, index, data}
  int          sel = 0;
  logic        m_valid, m_busy, m_done;
  logic [49:0] m_beat;
  always_comb begin
    m_valid = valid_a; m_busy = busy_a; m_done = done_a; m_beat = {kind_a, index_a, data_a};
    case (sel)
      1: begin m_valid = valid_b; m_busy = busy_b; m_done = done_b; m_beat = {kind_b, index_b, data_b}; end
      2: begin m_valid = valid_c; m_busy = busy_c; m_done = done_c; m_beat = {kind_c, index_c, data_c}; end
      default: ;
    endcase
  end

  logic [49:0] got[$];
  logic [49:0] want[$];
  logic [49:0] held_beat;
  logic        hold_pend = 1'b0;
  logic        busy_prev = 1'b0;
  int          nstart = 0;
  int          ndone = 0;
  int          busy_len = 0;

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_stable", 64'(m_beat), 64'(held_beat));
      end
      if (m_done) begin
        check("done_busy_excl", 64'(m_busy), 64'd0);
        ndone++;
      end
      if (m_busy && !busy_prev) begin
        nstart++;
        busy_len = 1;
      end else if (m_busy) begin
        busy_len++;
      end
      if (m_valid && ready) got.push_back(m_beat);
      hold_pend = m_valid && !ready;
      held_beat = m_beat;
      busy_prev = m_busy;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Beat list a dump must produce: PC, then registers, then the memory window
  task automatic build_want(input int nregs, input int base, input int nwords, input logic [31:0] pcv);
    want.delete();
    want.push_back({2'd0, 16'd0, pcv});
    for (int i = 0; i < nregs; i++) want.push_back({2'd1, 16'(i), rf[i]});
    for (int j = 0; j < nwords; j++) want.push_back({2'd2, 16'(j), mem[(base / 4) + j]});
  endtask

  task automatic compare_beats(input string tag);
    check({tag, "_count"}, 64'(got.size()), 64'(want.size()));
    for (int i = 0; i < want.size(); i++) begin
      if (i < got.size()) check({tag, "_beat"}, 64'(got[i]), 64'(want[i]));
    end
  endtask

  task automatic wait_done(input int bound, input bit rnd, input string tag);
    int n0 = ndone;
    int k = 0;
    while (ndone == n0 && k < bound) begin
      if (rnd) ready = 1'($urandom_range(0, 1));
      cyc();
      k++;
    end
    check({tag, "_done_seen"}, 64'(ndone != n0), 64'd1);
    ready = 1'b1;
  endtask

  int          n, s0, d0;
  logic        halt_seen;
  logic [5:0]  trace[$];
  logic [5:0]  twant[$];
  logic [31:0] addrs[$];

  initial begin
    rst = 1'b1; start_a = 0; start_b = 0; start_c = 0; ready = 1'b1; pc = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = '0;
    rf[8] = 32'h19;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[3] = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(valid_a), 0);
    check("rst_kind", 64'(kind_a), 0);
    check("rst_index", 64'(index_a), 0);
    check("rst_data", 64'(data_a), 0);
    check("rst_busy", 64'(busy_a), 0);
    check("rst_done", 64'(done_a), 0);
    check("rst_rf_raddr", 64'(rf_raddr_a), 0);
    check("rst_dm_raddr", 64'(dm_raddr_a), 0);
    rst = 1'b0;

    // Running core: PC moves every cycle, then parks at 0x4c
    for (int i = 0; i < 10; i++) begin
      pc = 32'h100 + 32'(4 * i);
      cyc();
    end
    check("no_trig_while_running", 64'(nstart), 0);
    pc = 32'h4c;
    n = 0;
    while (!busy_a && n < 40) begin
      cyc();
      n++;
    end
    check("auto_trig_latency", 64'(n >= 16 && n <= 19), 1);
    check("pc_cycle_not_valid", 64'(valid_a), 0);
    cyc();
    check("first_valid_2_after_trig", 64'(valid_a), 1);
    wait_done(200, 0, "auto");
    build_want(32, 0, 9, 32'h4c);
    compare_beats("auto");
    check("auto_busy_len", 64'(busy_len), 64'(2 + 2 * 41));
    check("auto_one_done", 64'(ndone), 1);
    repeat (60) cyc();
    check("auto_no_retrigger", 64'(nstart), 1);

    // Backpressure with a start pulse dropped in mid-dump
    got.delete();
    s0 = nstart; d0 = ndone;
    start_a = 1; cyc(); start_a = 0;
    for (int i = 0; i < 30; i++) begin
      ready = 1'($urandom_range(0, 1));
      cyc();
    end
    start_a = 1; cyc(); start_a = 0;
    wait_done(2000, 1, "bp");
    compare_beats("bp");
    repeat (5) cyc();
    check("bp_one_dump", 64'(nstart - s0), 1);
    check("bp_one_done", 64'(ndone - d0), 1);

    // start coincident with the halt trigger
    got.delete();
    s0 = nstart;
    pc = 32'h50;
    halt_seen = 1'b0;
    n = 0;
    while (!halt_seen && n < 40) begin
      cyc();
      halt_seen = dut_a.halt_trig;
      n++;
    end
    check("halt_reached", 64'(halt_seen), 1);
    start_a = 1; cyc(); start_a = 0;
    wait_done(200, 0, "coinc");
    build_want(32, 0, 9, 32'h50);
    compare_beats("coinc");
    repeat (40) cyc();
    check("coinc_one_dump", 64'(nstart - s0), 1);

    // Reset part-way through the register phase
    got.delete();
    d0 = ndone;
    start_a = 1; cyc(); start_a = 0;
    n = 0;
    while (got.size() < 10 && n < 200) begin
      cyc();
      n++;
    end
    @(negedge clk);
    #2;
    check("pre_rst_busy", 64'(busy_a), 1);
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(valid_a), 0);
    check("arst_busy", 64'(busy_a), 0);
    check("arst_done", 64'(done_a), 0);
    check("arst_payload", 64'({kind_a, index_a, data_a}), 0);
    check("arst_addrs", 64'({rf_raddr_a, dm_raddr_a}), 0);
    repeat (3) cyc();
    rst = 1'b0;
    check("arst_no_done", 64'(ndone - d0), 0);
    got.delete();
    start_a = 1; cyc(); start_a = 0;
    wait_done(200, 0, "post_rst");
    compare_beats("post_rst");

    // READ_LAT=1, 8 registers, no memory: REQ/WAIT/HOLD per beat
    repeat (3) cyc();
    sel = 1;
    got.delete();
    start_b = 1; cyc(); start_b = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      trace.push_back({valid_b, valid_b ? 5'd0 : rf_raddr_b});
    end
    twant.push_back({1'b0, 5'd0});
    twant.push_back({1'b1, 5'd0});
    for (int i = 0; i < 8; i++) begin
      twant.push_back({1'b0, 5'(i)});
      twant.push_back({1'b0, 5'(i)});
      twant.push_back({1'b1, 5'd0});
    end
    for (int i = 0; i < 26; i++) check("lat1_trace", 64'(trace[i]), 64'(twant[i]));
    wait_done(100, 0, "lat1");
    build_want(8, 0, 0, 32'h50);
    compare_beats("lat1");
    check("lat1_busy_len", 64'(busy_len), 64'(2 + 3 * 8));

    // Memory window at 0x20, two words
    repeat (3) cyc();
    sel = 2;
    got.delete();
    d0 = ndone;
    start_c = 1; cyc(); start_c = 0;
    n = 0;
    while (ndone == d0 && n < 100) begin
      @(negedge clk);
      if (busy_c && dm_raddr_c != 0) addrs.push_back(dm_raddr_c);
      n++;
    end
    check("win_done_seen", 64'(ndone - d0), 1);
    check("win_addr_count", 64'(addrs.size()), 2);
    if (addrs.size() == 2) begin
      check("win_addr0", 64'(addrs[0]), 64'h20);
      check("win_addr1", 64'(addrs[1]), 64'h24);
    end
    build_want(4, 32'h20, 2, 32'h50);
    compare_beats("win");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_state_dump.md
# mips_state_dump

In-circuit architectural-state dump engine for the single-cycle MIPS core. On a trigger, either an external `start` pulse or automatic halt detection when the PC stays constant for a programmable number of cycles, it walks the program counter, the register file and a window of data memory. It streams each value as a tagged beat over a valid/ready interface. It sits beside the `MIPS` top level, using the spare read ports of `RF` and `DM`, and replaces fixed-delay end-of-run inspection in benches and on FPGA.

## Interface
- `DATA_W`, 32: width of PC, register and memory words.
- `NREGS`, 32: registers dumped, indices 0..NREGS-1.
- `MEM_BASE`, 0: byte address of the first memory word dumped; must be word-aligned.
- `MEM_WORDS`, 9: number of 32-bit memory words dumped; 0 is legal and means no memory beats.
- `READ_LAT`, 0: read latency of `rf_rdata`/`dm_rdata` in cycles; 0 or 1.
- `AUTO_TRIG`, 1: enables halt-detection trigger.
- `STALL_CYCLES`, 16: consecutive unchanged-PC cycles that define a halt; at least 2.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle dump request.
- `pc_in`  in  DATA_W  live PC of the core.
- `rf_raddr`  out  5  register-file debug read address.
- `rf_rdata`  in  DATA_W  register-file debug read data.
- `dm_raddr`  out  DATA_W  data-memory byte address, word-aligned.
- `dm_rdata`  in  DATA_W  big-endian assembled word at `dm_raddr`.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  sink accepts beat.
- `out_kind`  out  2  0 = PC, 1 = register, 2 = memory, 3 = unused.
- `out_index`  out  16  register number or memory word number; 0 for the PC beat.
- `out_data`  out  DATA_W  beat payload.
- `busy`  out  1  dump in progress.
- `done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- States: IDLE, PC, REQ, WAIT, HOLD, DONE.
- IDLE: a trigger moves the FSM to PC and snapshots `pc_in` into `pc_snap` in the same cycle. A trigger is `start`, or `AUTO_TRIG` with `stall_cnt == STALL_CYCLES` and `armed` set.
- PC: loads `out_data = pc_snap`, kind 0, index 0, then goes to HOLD.
- REQ: drives `rf_raddr = idx` during the register phase, or `dm_raddr = MEM_BASE + 4*idx` during the memory phase.
  - `READ_LAT = 0`: loads `rdata` into the output register in the same cycle, then goes to HOLD.
  - `READ_LAT = 1`: goes to WAIT, and WAIT loads the data on the next cycle. Addresses are held stable through WAIT.
- HOLD: `out_valid = 1`, and payload, kind and index are held unchanged until `out_ready`.
  - On acceptance, `idx` advances.
  - When the register phase ends, the FSM switches to the memory phase with `idx = 0`.
  - When the memory phase ends, the FSM goes to DONE.
- DONE: `done = 1` for one cycle, clears `armed`, then returns to IDLE.
- Beat order: PC; R0..R(NREGS-1); M0..M(MEM_WORDS-1). Total beats = 1 + NREGS + MEM_WORDS.
- Halt detector, running in every state:
  - `stall_cnt` resets to 0 whenever `pc_in` differs from its previous-cycle value; otherwise it increments and saturates at `STALL_CYCLES`.
  - `armed` is set on any PC change and cleared in DONE. A halted core therefore does not retrigger endlessly.
- `start` or an auto trigger while `busy` is ignored, not queued.
- Simultaneous `start` and auto trigger produce a single dump.
- `rf_raddr` and `dm_raddr` are 0 when not in the respective phase.

## Timing
- Reset values: `out_valid = 0`, `out_kind = 0`, `out_index = 0`, `out_data = 0`, `busy = 0`, `done = 0`, `rf_raddr = 0`, `dm_raddr = 0`, `stall_cnt = 0`, `armed = 1`, state IDLE.
- `busy` rises on the cycle after the trigger and falls in the DONE cycle; `done` and `busy` are never high together.
- First `out_valid` is 2 cycles after the trigger edge.
- Per-beat occupancy is 2 + READ_LAT cycles when `out_ready` is held high (REQ, optional WAIT, HOLD). The PC beat takes 2 cycles.
- `rst` during a dump aborts immediately: `out_valid` drops asynchronously and no `done` pulse is produced.
- `out_valid` must not deassert without a handshake; the payload is stable while `out_valid && !out_ready`.

## Structure
- Shared package `mips_dbg_pkg`:
  - `out_kind` encodings `KIND_PC`, `KIND_REG`, `KIND_MEM`;
  - the FSM state enum;
  - `WORD_BYTES = 4`.
- Sub-module `mips_halt_detect`, parameterised by `DATA_W` and `STALL_CYCLES`, contains the PC compare, `stall_cnt` and `armed`, and outputs `halt_trig`.
- The main FSM, counters and output register live in `mips_state_dump`.

## Test plan
- Auto trigger with `READ_LAT = 0`, defaults: core loops at PC `0x4c` with `$t0 = 0x19` and M3 = `0x00000010`.
  - Dump starts 16 cycles after the PC freezes.
  - 42 beats, in order PC = `0x4c`, R8 = `0x19`, M3 = `0x10`.
  - One `done` pulse and no second dump.
- Backpressure: `out_ready` toggles pseudo-randomly.
  - Every HOLD payload is stable until accepted.
  - Beat count and order are identical to the free-running case.
- `READ_LAT = 1`, `NREGS = 8`, `MEM_WORDS = 0`: a `start` pulse yields exactly 9 beats, with the WAIT cycle visible and the address stable across it.
- `start` asserted during a dump and simultaneously with `halt_trig`: exactly one dump each time.
- `rst` pulsed mid-register phase at beat 10:
  - all outputs return to reset values asynchronously and `done` never pulses;
  - a subsequent `start` produces a full 42-beat dump.
- `MEM_BASE = 0x20`, `MEM_WORDS = 2`: `dm_raddr` sequence is `0x20`, `0x24`, and `out_index` is 0, 1.
